// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds 4 scanned seven-segment digits from an/seg_code
// Optional feature macro: SEG_ACTIVE_LOW_EN (invert an/seg_code at the input stage)
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg_code,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYC);
  localparam logic [7:0]  STAB_HIT = 8'(STABLE_CYC - 1);
  localparam logic [15:0] TOUT_MAX = 16'(TIMEOUT_CYC);

  logic [11:0] samp_q, samp_d, prev_q;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] sh_dig_q, sh_dig_d;
  logic [3:0]  sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d, blank_q, blank_d, err_q, err_d;
  logic        fv_q, fv_d;

  logic [3:0]  an_s;
  logic [7:0]  seg_s;
  logic        one_hot;
  logic        capture;
  logic [3:0]  dec_nib;
  logic        dec_blank;
  logic        dec_err;

  // Input stage: polarity correction before registering the raw lines
  always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
    samp_d = ~{an, seg_code};
`else
    samp_d = {an, seg_code};
`endif
  end

  // Stability counter and capture qualification on the registered sample
  always_comb begin
    an_s    = samp_q[11:8];
    seg_s   = samp_q[7:0];
    one_hot = (an_s != 4'd0) && ((an_s & (an_s - 4'd1)) == 4'd0);
    if (samp_q != prev_q) begin
      stab_d = 8'd0;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end else begin
      stab_d = stab_q;
    end
    capture = (stab_d == STAB_HIT) && one_hot;
  end

  // Segment pattern decode into nibble / blank / illegal flags
  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_s[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // Shadow update, seen mask, frame publish and timeout counter
  always_comb begin
    sh_dig_d   = sh_dig_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    digits_d   = digits_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    err_d      = err_q;
    fv_d       = 1'b0;
    seen_d     = seen_q;

    // A full mask publishes the shadows captured so far; the capture in
    // this same cycle lands in the shadow and starts the next frame.
    if (seen_q == 4'hF) begin
      digits_d = sh_dig_q;
      dp_d     = sh_dp_q;
      blank_d  = sh_blank_q;
      err_d    = sh_err_q;
      fv_d     = 1'b1;
      seen_d   = 4'h0;
    end

    if (capture) begin
      seen_d = seen_d | an_s;
      for (int i = 0; i < 4; i++) begin
        if (an_s[i]) begin
          sh_dig_d[4*i +: 4] = dec_nib;
          sh_dp_d[i]         = seg_s[7];
          sh_blank_d[i]      = dec_blank;
          sh_err_d[i]        = dec_err;
        end
      end
    end

    if (capture) begin
      tcnt_d = 16'd0;
    end else if (tcnt_q < TOUT_MAX) begin
      tcnt_d = tcnt_q + 16'd1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      prev_q     <= '0;
      stab_q     <= '0;
      tcnt_q     <= '0;
      seen_q     <= '0;
      sh_dig_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_err_q   <= '0;
      digits_q   <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      prev_q     <= samp_q;
      stab_q     <= stab_d;
      tcnt_q     <= tcnt_d;
      seen_q     <= seen_d;
      sh_dig_q   <= sh_dig_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q   <= sh_err_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;
  assign stale       = (tcnt_q == TOUT_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an;
  logic [7:0]  seg_code;
  logic [15:0] digits;
  logic [3:0]  dp, blank, err;
  logic        frame_valid, stale;

  // logical (active-high) stimulus; drive polarity follows the build
  logic [3:0]  lan  = 4'd0;
  logic [7:0]  lseg = 8'd0;

`ifdef SEG_ACTIVE_LOW_EN
  assign an       = ~lan;
  assign seg_code = ~lseg;
`else
  assign an       = lan;
  assign seg_code = lseg;
`endif

  seg_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an), .seg_code(seg_code),
    .digits(digits), .dp(dp), .blank(blank), .err(err),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int fv_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: decode table lookup, run-length of raw samples
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] m_sh, m_dig;
  logic [3:0]  m_shdp, m_shbl, m_sher, m_dp, m_bl, m_er, m_seen;
  logic        m_fv, m_stale;
  int          m_idle;
  logic [11:0] last_in;
  int          run;
  logic        pend;
  logic [11:0] pend_val;
  logic        started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_sh = 0; m_dig = 0; m_shdp = 0; m_shbl = 0; m_sher = 0;
      m_dp = 0; m_bl = 0; m_er = 0; m_seen = 0; m_fv = 0; m_stale = 0;
      m_idle = 0; last_in = 0; run = 1; pend = 0; pend_val = 0;
    end else begin
      m_fv = 1'b0;
      if (m_seen == 4'hF) begin
        m_dig = m_sh; m_dp = m_shdp; m_bl = m_shbl; m_er = m_sher;
        m_fv = 1'b1; m_seen = 0;
      end
      if (pend) begin
        for (int d = 0; d < 4; d++) begin
          if (pend_val[8+d]) begin
            logic [3:0] nib;
            logic       hit;
            nib = 0; hit = 0;
            for (int k = 0; k < 16; k++)
              if (pat[k] == pend_val[6:0]) begin nib = 4'(k); hit = 1; end
            m_sh[4*d +: 4] = nib;
            m_shdp[d] = pend_val[7];
            m_shbl[d] = (pend_val[6:0] == 7'h00);
            m_sher[d] = !hit && (pend_val[6:0] != 7'h00);
            m_seen[d] = 1'b1;
          end
        end
        m_idle = 0;
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
      end
      m_stale = (m_idle == TIMEOUT);
      if ({lan, lseg} == last_in) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
      end
      last_in  = {lan, lseg};
      pend     = (run == STABLE) && ($countones(lan) == 1);
      pend_val = {lan, lseg};
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("digits", 32'(digits), 32'(m_dig));
      check("dp", 32'(dp), 32'(m_dp));
      check("blank", 32'(blank), 32'(m_bl));
      check("err", 32'(err), 32'(m_er));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("stale", 32'(stale), 32'(m_stale));
      if (frame_valid) fv_count++;
    end
  end

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    lan = a; lseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    settle();
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_stale", 32'(stale), 32'h0);
    rst = 1'b0;

    // idle: stale appears exactly after TIMEOUT edges
    repeat (TIMEOUT - 1) @(negedge clk);
    settle();
    check("idle_stale_before", 32'(stale), 32'h0);
    @(negedge clk); settle();
    check("idle_stale_at", 32'(stale), 32'h1);
    repeat (1100 - TIMEOUT) @(negedge clk);
    settle();
    check("idle_stale_hold", 32'(stale), 32'h1);
    check("idle_no_fv", 32'(fv_count), 32'd0);

    // basic frame 4321
    dwell(4'b0001, 8'h06, 8);
    settle();
    check("stale_dropped", 32'(stale), 32'h0);
    dwell(4'b0010, 8'h5B, 8);
    dwell(4'b0100, 8'h4F, 8);
    dwell(4'b1000, 8'h66, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("f1_digits", 32'(digits), 32'h4321);
    check("f1_flags", 32'({dp, blank, err}), 32'h0);
    check("f1_fv", 32'(fv_count), 32'd1);

    // too-short dwells never capture
    dwell(4'b0001, 8'h06, 3);
    dwell(4'b0010, 8'h5B, 3);
    dwell(4'b0100, 8'h4F, 3);
    dwell(4'b1000, 8'h66, 3);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("short_digits", 32'(digits), 32'h4321);
    check("short_fv", 32'(fv_count), 32'd1);

    // blank / illegal / dp, with a re-capture of digit 0
    dwell(4'b0001, 8'h4F, 8);
    dwell(4'b0001, 8'h3F, 8);
    dwell(4'b0010, 8'h06, 8);
    dwell(4'b0100, 8'h00, 8);
    dwell(4'b1000, 8'hD5, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("f2_digits", 32'(digits), 32'h0010);
    check("f2_blank", 32'(blank), 32'b0100);
    check("f2_err", 32'(err), 32'b1000);
    check("f2_dp", 32'(dp), 32'b1000);
    check("f2_fv", 32'(fv_count), 32'd2);

    // multi-hot glitch in the middle of a frame
    dwell(4'b0001, 8'h7F, 8);
    dwell(4'b0010, 8'h77, 8);
    dwell(4'b0011, 8'h06, 20);
    dwell(4'b0100, 8'h39, 8);
    dwell(4'b1000, 8'hDE, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("f3_digits", 32'(digits), 32'hDCA8);
    check("f3_dp", 32'(dp), 32'b1000);
    check("f3_fv", 32'(fv_count), 32'd3);

    // reset after two digits discards the partial frame
    dwell(4'b0001, 8'h07, 8);
    dwell(4'b0010, 8'h07, 8);
    lan = 4'd0; lseg = 8'd0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    check("rst_digits", 32'(digits), 32'h0);
    dwell(4'b0100, 8'h6D, 8);
    dwell(4'b1000, 8'h7D, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("rst_partial_fv", 32'(fv_count), 32'd3);
    dwell(4'b0001, 8'h6F, 8);
    dwell(4'b0010, 8'h71, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("f4_digits", 32'(digits), 32'h65F9);
    check("f4_fv", 32'(fv_count), 32'd4);

    // all zeros in rotation
    dwell(4'b0001, 8'h3F, 8);
    dwell(4'b0010, 8'h3F, 8);
    dwell(4'b0100, 8'h3F, 8);
    dwell(4'b1000, 8'h3F, 8);
    dwell(4'b0000, 8'h00, 4);
    settle();
    check("f5_digits", 32'(digits), 32'h0000);
    check("f5_flags", 32'({dp, blank, err}), 32'h0);
    check("f5_fv", 32'(fv_count), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment drive (`an`, `seg_code`) produced by the responder/display blocks.
- Watches the scanned anode/segment lines and rebuilds the four displayed digits as hex nibbles, with per-digit blank, illegal-pattern and decimal-point flags.
- Used for on-board loopback self-check and as a scoreboard front end in simulation; raises a one-cycle strobe per completed frame.

Parameters:
- STABLE_CYC, default 4: consecutive identical samples of {an, seg_code} required before a digit is captured (range 1..255).
- TIMEOUT_CYC, default 1024: cycles without any capture before `stale` asserts (range 2..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- an  input  4  scanned digit enables, active-high, one-hot when valid; an[i] selects digit i
- seg_code  input  8  segment lines, active-high; bit0..bit6 = a..g, bit7 = dp
- digits  output  16  reconstructed values; digits[4i+3:4i] = digit i
- dp  output  4  decimal point per digit
- blank  output  4  digit i showed all segments off
- err  output  4  digit i showed a pattern outside the decode table
- frame_valid  output  1  one-cycle pulse when digits/dp/blank/err update
- stale  output  1  no capture for TIMEOUT_CYC cycles

Behaviour:
- Reset:
  - All outputs are 0; internal shadow registers, seen mask, stability and timeout counters are cleared.
  - Reset asserted mid-frame discards the partial frame; no `frame_valid` is produced for it.
- Input stage: {an, seg_code} is registered every cycle (1-cycle latency) before any comparison.
- Stability counter:
  - Cleared when the registered sample differs from the previous registered sample.
  - Otherwise increments, saturating at STABLE_CYC.
- Capture:
  - Occurs in the single cycle the counter reaches STABLE_CYC-1, i.e. the sample has held for STABLE_CYC edges.
  - Requires `an` to be one-hot; exactly one capture per dwell.
  - `an` equal to 0 or multi-hot never captures; it is silently ignored and does not clear the seen mask.
- Decode of seg_code[6:0] into the shadow for digit i:
  - Legal patterns: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 00: nibble 0, blank=1.
  - Any other pattern: nibble 0, err=1.
  - seg_code[7] is stored as dp[i].
- Seen mask:
  - Bit i is set on capture of digit i.
  - Re-capture of an already-seen digit overwrites its shadow; the newest value wins.
- Frame completion:
  - In the cycle after the seen mask becomes 4'hF, shadows copy to the outputs, `frame_valid`=1 for exactly one cycle, and the seen mask clears.
  - A capture in that same cycle sets its bit in the freshly cleared mask.
  - Outputs hold between frames.
- Timeout:
  - Counter increments each cycle without a capture, saturating at TIMEOUT_CYC; `stale`=1 while saturated.
  - Any capture zeroes the counter; `stale` drops in the following cycle.
- Scan order is irrelevant; any permutation of the four digits completes a frame.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: `an` and `seg_code` are inverted at the input stage, for common-anode boards; all rules above then apply to the inverted values.
- Undefined: inputs are used as-is (active-high); no inversion logic is present.

Test Plan:
- Reset then idle (an=0) for 1100 cycles → all outputs 0, `frame_valid` never pulses, `stale`=1 from cycle 1024 onward.
- Scan an=1,2,4,8 with seg 06,5B,4F,66, each held 8 cycles → one `frame_valid` pulse; digits=16'h4321, dp=0, blank=0, err=0; `stale` deasserts after the first capture.
- Same scan but each dwell held 3 cycles (STABLE_CYC=4) → no capture, no `frame_valid`, outputs unchanged.
- Digit 2 shows 00 and digit 3 shows 0x55 with dp set (seg_code=8'hD5) → blank=4'b0100, err=4'b1000, dp=4'b1000, digits[15:8]=0.
- an=4'b0011 held 20 cycles inside a frame, then the scan resumes → glitch ignored, frame completes with correct values; rst pulsed after 2 digits → no `frame_valid` until 4 new captures.
- With SEG_ACTIVE_LOW_EN: an=~4'b0001, seg_code=~8'h3F for all four digits in rotation → digits=16'h0000, blank=0, err=0, `frame_valid` pulses once.
